// File: rtl/wb_sram_slave_if.sv
// wb_if: Wishbone B4 signal bundle with master and slave views.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] adr;
  logic [2:0] cti;
  logic [1:0] bte;
  logic [DW-1:0] dat_w, dat_r;
  logic [DW/8-1:0] sel;
  logic cyc, stb, we, ack, err;
  modport slave (input adr, cti, bte, dat_w, sel, cyc, stb, we, output dat_r, ack, err);
  modport master (output adr, cti, bte, dat_w, sel, cyc, stb, we, input dat_r, ack, err);
endinterface

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone SRAM slave, one wait state per classic access.
// Define WB_SRAM_SLAVE_BURST_EN to add incrementing/wrapping bursts at one word per cycle.
module wb_sram_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE = '0
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int SH = $clog2(SW);
  localparam int MW = MEM_WORDS_LOG2;
  typedef enum logic [1:0] {IDLE, ACTIVE, BURST, ERROR} state_t;
  state_t state;
  logic [WB_DATA_WIDTH-1:0] mem [2**MW];
  logic [WB_DATA_WIDTH-1:0] rdata, rd_nxt;
  logic [WB_ADDR_WIDTH-1:0] off;
  logic [MW-1:0] addr, nxt_addr, adv;
  logic req, in_rng, ack, err, burst_go, ovf, unused_ok;
  assign req = s.cyc & s.stb;
  assign off = s.adr - ADDR_BASE;
  assign in_rng = s.adr >= ADDR_BASE && off[WB_ADDR_WIDTH-1:SH+MW] == '0;
  assign ack = req && (state == ACTIVE || state == BURST);
  assign err = req && state == ERROR;
  assign s.ack = ack;
  assign s.err = err;
  assign s.dat_r = ack ? rdata : '0;
`ifdef WB_SRAM_SLAVE_BURST_EN
  logic [MW-1:0] m;
  assign burst_go = s.cti == 3'b010;
  assign m = s.bte == 2'd1 ? MW'(3) : s.bte == 2'd2 ? MW'(7) : s.bte == 2'd3 ? MW'(15) : '1;
  assign adv = (addr & ~m) | ((addr + MW'(1)) & m);
  assign ovf = s.bte == 2'b00 && &addr;
  assign unused_ok = ^off;
`else
  assign burst_go = 1'b0;
  assign adv = addr;
  assign ovf = 1'b0;
  assign unused_ok = ^{off, s.cti, s.bte};
`endif
  assign nxt_addr = state == IDLE && req && in_rng ? off[SH+MW-1:SH] : ack && burst_go && !ovf ? adv : addr;
  // prefetch the word for the next cycle, merging a same-word write landing on this edge
  always_comb begin
    rd_nxt = mem[nxt_addr];
    for (int i = 0; i < SW; i++)
      if (ack && s.we && s.sel[i] && nxt_addr == addr) rd_nxt[8*i +: 8] = s.dat_w[8*i +: 8];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < SW; i++)
      if (ack && s.we && s.sel[i]) mem[addr][8*i +: 8] <= s.dat_w[8*i +: 8];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      addr <= '0;
      rdata <= '0;
    end else begin
      addr <= nxt_addr;
      rdata <= rd_nxt;
      case (state)
        IDLE: state <= !req ? IDLE : in_rng ? ACTIVE : ERROR;
        ACTIVE: state <= !(ack && burst_go) ? IDLE : ovf ? ERROR : BURST;
        BURST: state <= !s.cyc ? IDLE : !s.stb ? BURST : !burst_go ? IDLE : ovf ? ERROR : BURST;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: randomized classic and burst traffic checked against a word-array SRAM model.
module tb_wb_sram_slave;
  localparam int MWL = 5;
  localparam int NW = 32;
  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef WB_SRAM_SLAVE_BURST_EN
  localparam int BW = 0;
`else
  localparam int BW = 1;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [NW];
  wb_if bus ();
  wb_sram_slave #(.MEM_WORDS_LOG2(MWL), .ADDR_BASE(BASE)) dut (.clk(clk), .rstn(rstn), .s(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    for (int i = 0; i < 4; i++) if (sel[i]) old[8*i +: 8] = d[8*i +: 8];
    return old;
  endfunction

  task automatic idle(input int n);
    bus.cyc = 0;
    bus.stb = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic we, input int word, input logic [31:0] d, input logic [3:0] sel,
                      input logic [2:0] cti, input logic [1:0] bte,
                      output int waits, output logic a, output logic e, output logic [31:0] rd);
    bus.cyc = 1;
    bus.stb = 1;
    bus.we = we;
    bus.adr = BASE + 32'(word) * 4;
    bus.dat_w = d;
    bus.sel = sel;
    bus.cti = cti;
    bus.bte = bte;
    waits = 0;
    a = 0;
    e = 0;
    rd = 0;
    for (int k = 0; k < 16 && !a && !e; k++) begin
      @(negedge clk);
      a = bus.ack;
      e = bus.err;
      rd = bus.dat_r;
      chk("ack_err_excl", 32'(a & e), 0);
      if (!a) chk("datr_zero", rd, 0);
      @(posedge clk);
      #1;
      if (!a && !e) waits++;
    end
  endtask

  task automatic classic(input logic we, input int word, input logic [31:0] d, input logic [3:0] sel);
    int w;
    logic a, e;
    logic [31:0] rd;
    logic ok;
    ok = word >= 0 && word < NW;
    xfer(we, word, d, sel, 3'b000, 2'b00, w, a, e, rd);
    bus.cyc = 0;
    bus.stb = 0;
    chk("cl_wait", w, 1);
    chk("cl_ack", 32'(a), 32'(ok));
    chk("cl_err", 32'(e), 32'(!ok));
    if (ok && we) ref_mem[word] = merge(ref_mem[word], d, sel);
    if (ok && !we) chk("cl_rdata", rd, ref_mem[word]);
  endtask

  task automatic burst(input logic we, input int start, input int n, input logic [1:0] bte,
                       input int stall_at, input int stall_len);
    int word, w, blk;
    logic a, e;
    logic [31:0] rd, d;
    logic [3:0] sel;
    word = start;
    blk = bte == 2'd0 ? 0 : 4 << (int'(bte) - 1);
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      sel = 4'($urandom_range(0, 15));
      xfer(we, word, d, sel, i == n - 1 ? 3'b111 : 3'b010, bte, w, a, e, rd);
      if (word >= NW) begin
        chk("bu_ovf_err", 32'(e), 1);
        chk("bu_ovf_ack", 32'(a), 0);
        chk("bu_ovf_wait", w, BW);
        break;
      end
      chk("bu_wait", w, i == 0 ? 1 : BW);
      chk("bu_ack", 32'(a), 1);
      if (we) ref_mem[word] = merge(ref_mem[word], d, sel);
      else chk("bu_rdata", rd, ref_mem[word]);
      if (i == stall_at) begin
        bus.stb = 0;
        repeat (stall_len) begin
          @(negedge clk);
          chk("bu_stall_ack", 32'(bus.ack), 0);
          @(posedge clk);
          #1;
        end
      end
      word = blk == 0 ? word + 1 : (word / blk) * blk + (word + 1) % blk;
    end
    bus.cyc = 0;
    bus.stb = 0;
  endtask

  initial begin
    int w, n, acks, st;
    logic a, e, seen;
    logic [31:0] rd;
    logic [1:0] bte;
    bus.cyc = 1;
    bus.stb = 1;
    bus.we = 0;
    bus.adr = BASE;
    bus.cti = 0;
    bus.bte = 0;
    bus.sel = '1;
    bus.dat_w = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_datr", bus.dat_r, 0);
    end
    @(posedge clk);
    #1;
    rstn = 1;
    for (int i = 0; i < NW; i++) begin
      classic(1, i, $urandom, 4'hf);
      idle($urandom_range(0, 2));
    end
    classic(1, 1, 32'hFFFF_FFFF, 4'hf);
    idle(1);
    classic(1, 1, 32'hA5A5_1234, 4'b0011);
    idle(1);
    xfer(0, 1, 0, 4'hf, 3'b000, 2'b00, w, a, e, rd);
    idle(1);
    chk("r029_wait", w, 1);
    chk("r029_data", rd, 32'hFFFF_1234);
    classic(0, NW, 0, 4'hf);
    idle(1);
    classic(0, -1, 0, 4'hf);
    idle(1);
    classic(1, NW + 3, 32'hDEAD_BEEF, 4'hf);
    idle(1);
    repeat (80) begin
      classic(1'($urandom), $urandom_range(0, NW + 3) - 1, $urandom, 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end
    burst(0, 2, 4, 2'b01, -1, 0);
    idle(1);
    burst(1, 10, 3, 2'b00, 0, 2);
    idle(1);
    for (int i = 9; i < 14; i++) classic(0, i, 0, 4'hf);
    idle(1);
    burst(1, 30, 4, 2'b00, -1, 0);
    idle(1);
    classic(0, 31, 0, 4'hf);
    classic(0, 0, 0, 4'hf);
    idle(1);
    repeat (14) begin
      bte = 2'($urandom_range(0, 3));
      n = $urandom_range(2, 8);
      st = bte == 0 ? $urandom_range(0, NW - n) : $urandom_range(0, NW - 1);
      burst(1'($urandom), st, n, bte, $urandom_range(0, n - 1) - 1, $urandom_range(1, 3));
      idle($urandom_range(0, 2));
      classic(0, $urandom_range(0, NW - 1), 0, 4'hf);
      idle($urandom_range(0, 1));
    end
    acks = 0;
    bus.cyc = 1;
    bus.stb = 1;
    bus.we = 0;
    bus.adr = BASE + 16;
    bus.cti = 3'b010;
    bus.bte = 2'b00;
    bus.sel = '1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = bus.ack;
      if (seen) acks++;
      if (acks == 2) break;
      @(posedge clk);
      #1;
      if (seen) bus.adr = bus.adr + 4;
    end
    chk("mid_acks", acks, 2);
    #1 rstn = 0;
    #1;
    chk("mid_rst_ack", 32'(bus.ack), 0);
    chk("mid_rst_datr", bus.dat_r, 0);
    chk("mid_rst_err", 32'(bus.err), 0);
    bus.cyc = 0;
    bus.stb = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rstn = 1;
    classic(0, 5, 0, 4'hf);
    idle(1);
    for (int i = 0; i < NW; i++) classic(0, i, 0, 4'hf);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
